// File: rtl/uart_pkg.sv
// Shared definitions for the UART library's bidirectional pad sequencer.
// Holds the FSM state type, the direction encoding and the default data width.
package uart_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    DRIVE,
    SAMPLE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bidir_bus_ctrl_if.sv
// Requester handshakes plus the pad-cell connections of the bidirectional bus sequencer.
// The slave modport is the controller; the master modport is the requesters and pad cell.
interface bidir_bus_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              oe;
  logic [DATA_W-1:0] bus_out;
  logic [DATA_W-1:0] bus_in;
  logic              busy;

  modport master (
    output wr_req, wr_data, rd_req, bus_in,
    input  wr_ack, rd_data, rd_valid, oe, bus_out, busy
  );

  modport slave (
    input  wr_req, wr_data, rd_req, bus_in,
    output wr_ack, rd_data, rd_valid, oe, bus_out, busy
  );

endinterface

// File: rtl/phase_cnt.sv
// Loadable down-counter timing the TURN, DRIVE and SAMPLE phases.
// done marks the final cycle of a phase (count of 1); the counter rests at 0.
module phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Arbitrates one writer and one reader onto the shared tri-state data pad,
// inserting oe=0 turnaround gaps whenever the bus direction changes.
module bidir_bus_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int TURN_CYCLES   = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int SAMPLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  bidir_bus_ctrl_if.slave bus
);

  localparam int MAX_CYC = max3(TURN_CYCLES, HOLD_CYCLES, SAMPLE_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES);

  state_t            state, state_n;
  logic              dir;
  logic              last_grant;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              grant;
  logic              grant_dir;
  logic              set_dir;
  logic              capture;
  logic              load;
  logic [CNT_W-1:0]  load_val;
  logic              phase_done;

  phase_cnt #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (phase_done)
  );

  // Next-state logic; while a turnaround is pending, last_grant remembers which phase follows it.
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    grant_dir = DIR_READ;
    set_dir   = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      IDLE: begin
        if (bus.wr_req || bus.rd_req) begin
          grant     = 1'b1;
          grant_dir = (bus.wr_req && (!bus.rd_req || last_grant == DIR_READ)) ? DIR_WRITE : DIR_READ;
          load      = 1'b1;
          if (grant_dir != dir) begin
            state_n  = TURN;
            load_val = TURN_LD;
          end else if (grant_dir == DIR_WRITE) begin
            state_n  = DRIVE;
            load_val = HOLD_LD;
          end else begin
            state_n  = SAMPLE;
            load_val = SAMPLE_LD;
          end
        end
      end
      TURN: begin
        if (phase_done) begin
          set_dir = 1'b1;
          load    = 1'b1;
          if (last_grant == DIR_WRITE) begin
            state_n  = DRIVE;
            load_val = HOLD_LD;
          end else begin
            state_n  = SAMPLE;
            load_val = SAMPLE_LD;
          end
        end
      end
      DRIVE: begin
        if (phase_done) begin
          state_n = IDLE;
        end
      end
      SAMPLE: begin
        if (phase_done) begin
          state_n = IDLE;
          capture = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= DIR_READ;
      last_grant <= DIR_READ;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      rd_valid_q <= capture;
      if (grant) begin
        last_grant <= grant_dir;
      end
      if (grant && grant_dir == DIR_WRITE) begin
        wdata_q <= bus.wr_data;
      end
      if (set_dir) begin
        dir <= last_grant;
      end
      if (capture) begin
        rd_data_q <= bus.bus_in;
      end
    end
  end

  // Decoded only from registers, so oe moves on clock edges and drops at once on reset.
  assign bus.oe       = (dir == DIR_WRITE) && (state == IDLE || state == DRIVE);
  assign bus.bus_out  = wdata_q;
  assign bus.wr_ack   = (state == DRIVE) && phase_done;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: a transaction-schedule model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_bidir_bus_ctrl;

  localparam int DW   = 8;
  localparam int TURN = 2;
  localparam int HOLD = 1;
  localparam int SAMP = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  bidir_bus_ctrl_if #(.DATA_W(DW)) bif ();

  bidir_bus_ctrl #(
    .DATA_W        (DW),
    .TURN_CYCLES   (TURN),
    .HOLD_CYCLES   (HOLD),
    .SAMPLE_CYCLES (SAMP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // Expected per-cycle pad/handshake behaviour, scheduled a whole transfer at a time.
  typedef struct {
    logic          oe;
    logic [DW-1:0] bus;
    logic          ack;
    logic          busy;
    logic          capture;
  } rec_t;

  rec_t          sched[$];
  rec_t          exp_r;
  bit            exp_idle;
  logic          exp_rv;
  logic          m_dir;
  logic          m_last;
  logic [DW-1:0] m_bus;
  logic [DW-1:0] m_rd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic rec_t idleRec();
    rec_t r;
    r.oe      = m_dir;
    r.bus     = m_bus;
    r.ack     = 1'b0;
    r.busy    = 1'b0;
    r.capture = 1'b0;
    return r;
  endfunction

  task automatic modelReset();
    sched.delete();
    m_dir    = 1'b0;
    m_last   = 1'b0;
    m_bus    = '0;
    m_rd     = '0;
    exp_rv   = 1'b0;
    exp_idle = 1'b1;
    exp_r    = idleRec();
  endtask

  task automatic modelStep();
    logic gw;
    logic nrv;
    rec_t r;
    nrv = 1'b0;
    if (exp_r.capture) begin
      m_rd = bif.bus_in;
      nrv  = 1'b1;
    end
    if (exp_idle && (bif.wr_req || bif.rd_req)) begin
      gw     = bif.wr_req && (!bif.rd_req || !m_last);
      m_last = gw;
      if (gw != m_dir) begin
        for (int i = 0; i < TURN; i++) begin
          r.oe = 1'b0; r.bus = m_bus; r.ack = 1'b0; r.busy = 1'b1; r.capture = 1'b0;
          sched.push_back(r);
        end
      end
      m_dir = gw;
      if (gw) begin
        m_bus = bif.wr_data;
        for (int i = 0; i < HOLD; i++) begin
          r.oe = 1'b1; r.bus = m_bus; r.ack = (i == HOLD - 1); r.busy = 1'b1; r.capture = 1'b0;
          sched.push_back(r);
        end
      end else begin
        for (int i = 0; i < SAMP; i++) begin
          r.oe = 1'b0; r.bus = m_bus; r.ack = 1'b0; r.busy = 1'b1; r.capture = (i == SAMP - 1);
          sched.push_back(r);
        end
      end
    end
    if (sched.size() > 0) begin
      exp_r    = sched.pop_front();
      exp_idle = 1'b0;
    end else begin
      exp_r    = idleRec();
      exp_idle = 1'b1;
    end
    exp_rv = nrv;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  // Compare every cycle on the falling edge, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_oe",       32'(bif.oe),       32'(exp_r.oe));
      checkOutput("model_busy",     32'(bif.busy),     32'(exp_r.busy));
      checkOutput("model_wr_ack",   32'(bif.wr_ack),   32'(exp_r.ack));
      checkOutput("model_rd_valid", 32'(bif.rd_valid), 32'(exp_rv));
      checkOutput("model_rd_data",  32'(bif.rd_data),  32'(m_rd));
      if (exp_r.oe) begin
        checkOutput("model_bus_out", 32'(bif.bus_out), 32'(exp_r.bus));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic [DW-1:0] bi);
    bif.wr_req  = wr;
    bif.wr_data = wd;
    bif.rd_req  = rd;
    bif.bus_in  = bi;
  endtask

  task automatic doWrite(input logic [DW-1:0] d);
    int n;
    bif.wr_req  = 1'b1;
    bif.wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.wr_ack && n < 50);
    checkOutput("wr_ack_timeout", 32'(bif.wr_ack), 32'd1);
    bif.wr_req = 1'b0;
  endtask

  initial begin
    int   n;
    int   nw;
    int   nr;
    bit   order[$];

    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("rst_oe",       32'(bif.oe),       32'd0);
      checkOutput("rst_busy",     32'(bif.busy),     32'd0);
      checkOutput("rst_wr_ack",   32'(bif.wr_ack),   32'd0);
      checkOutput("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
      checkOutput("rst_rd_data",  32'(bif.rd_data),  32'd0);
    end

    // First write after reset needs a turnaround.
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("w1_c1_oe",   32'(bif.oe),   32'd0);
    checkOutput("w1_c1_busy", 32'(bif.busy), 32'd1);
    @(negedge clk);
    checkOutput("w1_c2_oe",   32'(bif.oe),   32'd0);
    @(negedge clk);
    checkOutput("w1_c3_oe",   32'(bif.oe),      32'd1);
    checkOutput("w1_c3_bus",  32'(bif.bus_out), 32'hA5);
    checkOutput("w1_c3_ack",  32'(bif.wr_ack),  32'd1);
    applyStimulus(1'b0, 8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("w1_c4_oe",   32'(bif.oe),      32'd1);
    checkOutput("w1_c4_bus",  32'(bif.bus_out), 32'hA5);
    checkOutput("w1_c4_ack",  32'(bif.wr_ack),  32'd0);

    // Back-to-back writes with the bus already parked in write direction.
    applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b2b_c1_ack", 32'(bif.wr_ack),  32'd1);
    checkOutput("b2b_c1_bus", 32'(bif.bus_out), 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b2b_c2_ack", 32'(bif.wr_ack),  32'd0);
    checkOutput("b2b_c2_oe",  32'(bif.oe),      32'd1);
    checkOutput("b2b_c2_bus", 32'(bif.bus_out), 32'h11);
    @(negedge clk);
    checkOutput("b2b_c3_ack", 32'(bif.wr_ack),  32'd1);
    checkOutput("b2b_c3_bus", 32'(bif.bus_out), 32'h22);
    applyStimulus(1'b0, 8'h22, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b2b_c4_ack", 32'(bif.wr_ack),  32'd0);

    // Read after write: oe drops, turnaround, sample, then rd_valid.
    applyStimulus(1'b0, 8'h22, 1'b1, 8'h5A);
    @(negedge clk);
    checkOutput("rd_c1_oe",    32'(bif.oe),       32'd0);
    checkOutput("rd_c1_busy",  32'(bif.busy),     32'd1);
    @(negedge clk);
    checkOutput("rd_c2_oe",    32'(bif.oe),       32'd0);
    @(negedge clk);
    checkOutput("rd_c3_valid", 32'(bif.rd_valid), 32'd0);
    @(negedge clk);
    checkOutput("rd_c4_valid", 32'(bif.rd_valid), 32'd1);
    checkOutput("rd_c4_data",  32'(bif.rd_data),  32'h5A);
    checkOutput("rd_c4_busy",  32'(bif.busy),     32'd0);
    applyStimulus(1'b0, 8'h22, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("rd_c5_valid", 32'(bif.rd_valid), 32'd0);
    checkOutput("rd_c5_data",  32'(bif.rd_data),  32'h5A);

    // Both requests held from reset: strict W,R alternation with a turnaround each time.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'h30, 1'b1, 8'hC0);
    n  = 0;
    nw = 0;
    nr = 0;
    while (nw + nr < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (bif.wr_ack) begin
        order.push_back(1'b1);
        nw++;
        if (nw < 4) bif.wr_data = 8'(8'h30 + nw);
        else        bif.wr_req  = 1'b0;
      end
      if (bif.rd_valid) begin
        checkOutput("tie_rd_data", 32'(bif.rd_data), 32'(8'hC0 + nr));
        order.push_back(1'b0);
        nr++;
        bif.bus_in = 8'(8'hC0 + nr);
        if (nr == 4) bif.rd_req = 1'b0;
      end
    end
    checkOutput("tie_count",  32'(order.size()), 32'd8);
    checkOutput("tie_cycles", 32'(n),            32'd32);
    for (int i = 0; i < order.size(); i++) begin
      checkOutput("tie_order", 32'(order[i]), 32'((i % 2) == 0));
    end
    @(negedge clk);

    // Reset pulse in the middle of a DRIVE phase.
    doWrite(8'h77);
    @(negedge clk);
    applyStimulus(1'b1, 8'h99, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstd_oe",     32'(bif.oe),     32'd0);
    checkOutput("rstd_busy",   32'(bif.busy),   32'd0);
    checkOutput("rstd_wr_ack", 32'(bif.wr_ack), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstd_after_oe",   32'(bif.oe),   32'd0);
    checkOutput("rstd_after_busy", 32'(bif.busy), 32'd0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("rstd_w_c1_oe",  32'(bif.oe),      32'd0);
    @(negedge clk);
    checkOutput("rstd_w_c2_oe",  32'(bif.oe),      32'd0);
    @(negedge clk);
    checkOutput("rstd_w_c3_ack", 32'(bif.wr_ack),  32'd1);
    checkOutput("rstd_w_c3_bus", 32'(bif.bus_out), 32'h3C);
    applyStimulus(1'b0, 8'h3C, 1'b0, 8'h00);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
# bidir_bus_ctrl

Sequencer for the UART library's shared 8-bit bidirectional data pad (the `bidirec` output-enable/tri-state cell). It arbitrates between one write requester and one read requester and drives `oe` and `inp` to the pad cell. It captures the pad cell's `outp` for reads. It inserts bus-turnaround gaps whenever the direction changes, so the line is never driven from both ends at once.

## Interface
Parameters:
- DATA_W, 8, pad/data width
- TURN_CYCLES, 2, idle cycles (`oe`=0) on every direction change; legal range ≥1
- HOLD_CYCLES, 1, cycles write data is presented before ack; legal range ≥1
- SAMPLE_CYCLES, 1, settle cycles before read capture; legal range ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request, level; held until wr_ack
- wr_data  in  DATA_W  write data; captured at grant
- wr_ack  out  1  one-cycle pulse; write completed
- rd_req  in  1  read request, level; held until rd_valid
- rd_data  out  DATA_W  captured read data; holds until next capture
- rd_valid  out  1  one-cycle pulse; rd_data is new
- oe  out  1  to pad cell `oe`; 1 = drive the bus
- bus_out  out  DATA_W  to pad cell `inp`
- bus_in  in  DATA_W  from pad cell `outp`
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, TURN, DRIVE, SAMPLE. Registers: `dir` (0=read, 1=write), `last_grant`, phase counter.
- Reset values: state=IDLE, dir=read, last_grant=read, oe=0, bus_out=0, rd_data=0, wr_ack=0, rd_valid=0, busy=0.
- IDLE arbitration:
  - Only one request active: grant it.
  - Both requests active: grant the opposite of `last_grant` (round-robin). After reset, a write therefore wins the first tie.
  - Grant updates `last_grant`. A write grant also latches `wr_data`.
- Transitions from IDLE on grant:
  - Granted direction equals `dir`: go to DRIVE (write) or SAMPLE (read).
  - Granted direction differs from `dir`: go to TURN.
- TURN:
  - oe=0 for TURN_CYCLES cycles.
  - On exit, `dir` is set to the granted direction, then the FSM goes to DRIVE or SAMPLE.
- DRIVE:
  - oe=1 and bus_out=latched data for HOLD_CYCLES cycles.
  - wr_ack is high in the last DRIVE cycle; the FSM then returns to IDLE.
- Parked state while dir=write: oe stays 1 and bus_out holds the last data, including in IDLE.
- SAMPLE:
  - oe=0 for SAMPLE_CYCLES cycles.
  - `bus_in` is registered into rd_data at the end of the last cycle.
  - rd_valid is high the following cycle, which is the first IDLE cycle.
- Requests seen in the same cycle as their own ack/valid are treated as new requests. Requesters must deassert or present new data in that cycle.
- Reset asserted mid-operation: all registers go to reset values immediately and oe=0 asynchronously. In-flight transfers are dropped with no ack/valid.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled. Default parameters.
- Write, dir=write: DRIVE in c1 (wr_ack in c1); IDLE in c2. Sustained rate: one write per 2 cycles.
- Write, dir=read: TURN in c1–c2 (oe=0); DRIVE in c3 (oe=1, wr_ack=1).
- Read, dir=read: SAMPLE in c1; capture at the c1→c2 edge; rd_valid in c2.
- Read, dir=write: oe falls in c1; TURN in c1–c2; SAMPLE in c3; rd_valid in c4.
- General latencies:
  - Write: 1 cycle from grant to bus drive.
  - Read: SAMPLE_CYCLES+1 cycles from request to rd_valid.
  - Add TURN_CYCLES to either on a direction change.
- oe changes only on clock edges, except for asynchronous reset.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, TURN, DRIVE, SAMPLE}
  - DIR_READ/DIR_WRITE constants
  - default DATA_W
- Sub-module `phase_cnt`:
  - loadable down-counter
  - width $clog2(max(TURN_CYCLES, HOLD_CYCLES, SAMPLE_CYCLES)+1)
  - `done` flag at count 1
  - reused for all three timed phases

## Test plan
- Reset release, no requests → oe=0, busy=0, wr_ack=rd_valid=0, rd_data=0 for 20 cycles.
- wr_req with wr_data=0xA5 after reset → TURN for 2 cycles with oe=0; c3 oe=1, bus_out=0xA5, wr_ack=1; oe stays 1 afterwards.
- Back-to-back writes 0x11, 0x22 with dir=write → no TURN; bus_out=0x11 then 0x22 on the bus two cycles apart; one wr_ack per write.
- rd_req after a write, pad returning 0x5A → oe=0 in c1; rd_valid=1 with rd_data=0x5A in c4.
- wr_req and rd_req held together from reset for 8 transfers → grants alternate W,R,W,R…; a TURN occurs between every pair of transfers.
- rst_n pulsed low during DRIVE → oe=0 immediately, no wr_ack; after release state=IDLE and dir=read.
